ifu_prefetch: RTL and testbench

Parametrised successor to the single-outstanding fetch stage. It generates sequential PCs from a reset vector and issues instruction reads over a valid/ready address/data bus. It buffers fetched instructions with their PC in a prefetch FIFO of configurable depth and supports redirect with flush and discard of an in-flight response. It sits between the PC/branch logic and decode; decode consumes entries through a valid/ready interface.

---
 rtl/ifu_prefetch_if.sv | 28 ++
 rtl/ifu_prefetch.sv | 149 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - fetch bus (ar/r) and decode-side instruction stream bundle
interface ifu_prefetch_if #(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64
);
    logic             ar_valid;
    logic             ar_ready;
    logic [31:0]      ar_addr;
    logic             r_valid;
    logic             r_ready;
    logic [BUS_W-1:0] r_data;
    logic             r_err;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    logic             inst_err;

    modport master (
        output ar_valid, ar_addr, r_ready, inst_valid, inst, inst_pc, inst_err,
        input  ar_ready, r_valid, r_data, r_err, inst_ready
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready, inst_valid, inst, inst_pc, inst_err,
        output ar_ready, r_valid, r_data, r_err, inst_ready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetcher with redirect/flush and prefetch FIFO
module ifu_prefetch #(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          BUS_W    = 64,
    parameter int          FQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    ifu_prefetch_if.master            bus,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);
    localparam int          AW        = $clog2(FQ_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] ADDR_MASK = (BUS_W == 64) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_addr_q;
    logic            pending_flush_q, pending_flush_d;
    logic [XLEN-1:0] redirect_pc_word;

    logic [31:0]     inst_mem [FQ_DEPTH];
    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic            err_mem  [FQ_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            head_valid;
    logic            enq, deq, credit;
    logic [31:0]     beat_inst;

    assign redirect_pc_word = redirect_pc & ~XLEN'(3);

    generate
        if (BUS_W == 64) begin : g_bus64
            assign beat_inst = fetch_pc_q[2] ? bus.r_data[63:32] : bus.r_data[31:0];
        end else begin : g_bus32
            assign beat_inst = bus.r_data[31:0];
        end
    endgenerate

    // A redirect wins over both queue operations in the same cycle.
    assign head_valid = (count_q != '0);
    assign enq        = (state_q == DATA) && bus.r_valid && !redirect_valid;
    assign deq        = head_valid && bus.inst_ready && !redirect_valid;

    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Only one request is ever outstanding, so a free slot now is a slot for its response.
    assign credit = (count_d < CW'(FQ_DEPTH));

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        pending_flush_d = pending_flush_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_word;
        end
        case (state_q)
            IDLE: begin
                if (!redirect_valid && credit) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus.ar_ready) begin
                    state_d         = (redirect_valid || pending_flush_q) ? DRAIN : DATA;
                    pending_flush_d = 1'b0;
                end else if (redirect_valid) begin
                    pending_flush_d = 1'b1;
                end
            end
            DATA: begin
                if (redirect_valid) begin
                    state_d = bus.r_valid ? IDLE : DRAIN;
                end else if (bus.r_valid) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = credit ? ADDR : IDLE;
                end
            end
            DRAIN: begin
                if (bus.r_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC[XLEN-1:0];
            req_addr_q      <= '0;
            pending_flush_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            pending_flush_q <= pending_flush_d;
            count_q         <= count_d;
            // The address is captured on entry so a redirect while waiting cannot disturb it.
            if (state_d == ADDR && state_q != ADDR) begin
                req_addr_q <= fetch_pc_d[31:0] & ADDR_MASK;
            end
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[wr_ptr_q] <= beat_inst;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            err_mem[wr_ptr_q]  <= bus.r_err;
        end
    end

    assign bus.ar_valid   = (state_q == ADDR);
    assign bus.ar_addr    = req_addr_q;
    assign bus.r_ready    = (state_q == DATA) || (state_q == DRAIN);
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_valid ? inst_mem[rd_ptr_q] : '0;
    assign bus.inst_pc    = head_valid ? pc_mem[rd_ptr_q] : '0;
    assign bus.inst_err   = head_valid ? err_mem[rd_ptr_q] : 1'b0;
    assign fq_count       = count_q;
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch (64-bit and 32-bit bus builds)
module tb_ifu_prefetch;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        err;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rv64, rv32;
    logic [63:0] rpc64, rpc32;
    logic [2:0]  fq64, fq32;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_ar64[$];
    logic [31:0] exp_ar32[$];
    ent_t        exp_in64[$];
    ent_t        exp_in32[$];

    int          budget64 = 0, budget32 = 0;
    int          r_delay64 = 0;
    int          ar_count64 = 0;
    logic        err_arm = 1'b0;
    logic [31:0] err_addr = 32'h0;

    ifu_prefetch_if #(.XLEN(64), .BUS_W(64)) b64 ();
    ifu_prefetch_if #(.XLEN(64), .BUS_W(32)) b32 ();

    ifu_prefetch #(.BUS_W(64)) dut64 (
        .clk(clk), .rst(rst_n), .redirect_valid(rv64), .redirect_pc(rpc64),
        .bus(b64), .fq_count(fq64)
    );

    ifu_prefetch #(.BUS_W(32)) dut32 (
        .clk(clk), .rst(rst_n), .redirect_valid(rv32), .redirect_pc(rpc32),
        .bus(b32), .fq_count(fq32)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0004) return 32'h0010_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic ent_t mk(input logic [31:0] i, input logic [63:0] pc, input logic e);
        ent_t r;
        r.inst = i;
        r.pc   = pc;
        r.err  = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory slave for the 64-bit build: drives just after the falling edge.
    initial begin
        logic        have = 1'b0;
        logic [31:0] haddr = '0;
        int          wcnt = 0;
        b64.ar_ready = 1'b0; b64.r_valid = 1'b0; b64.r_data = '0; b64.r_err = 1'b0;
        forever begin
            @(negedge clk); #1;
            b64.r_valid = 1'b0; b64.r_data = '0; b64.r_err = 1'b0;
            if (have) begin
                if (wcnt > 0) begin
                    wcnt--;
                end else begin
                    b64.r_valid = 1'b1;
                    b64.r_data  = {word_at(haddr + 32'd4), word_at(haddr)};
                    b64.r_err   = err_arm && (haddr == err_addr);
                    if (b64.r_ready) begin
                        have = 1'b0;
                        if (b64.r_err) err_arm = 1'b0;
                    end
                end
            end
            b64.ar_ready = (budget64 > 0);
            if (b64.ar_valid && b64.ar_ready) begin
                budget64--;
                ar_count64++;
                if (exp_ar64.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL ar64_unexpected: got 0x%0h, expected none", b64.ar_addr);
                end else begin
                    check("ar_addr64", 64'(b64.ar_addr), 64'(exp_ar64.pop_front()));
                end
                have  = 1'b1;
                haddr = b64.ar_addr;
                wcnt  = r_delay64;
            end
        end
    end

    // Memory slave for the 32-bit build: zero-wait, no errors.
    initial begin
        logic        have = 1'b0;
        logic [31:0] haddr = '0;
        b32.ar_ready = 1'b0; b32.r_valid = 1'b0; b32.r_data = '0; b32.r_err = 1'b0;
        forever begin
            @(negedge clk); #1;
            b32.r_valid = 1'b0; b32.r_data = '0;
            if (have) begin
                b32.r_valid = 1'b1;
                b32.r_data  = word_at(haddr);
                if (b32.r_ready) have = 1'b0;
            end
            b32.ar_ready = (budget32 > 0);
            if (b32.ar_valid && b32.ar_ready) begin
                budget32--;
                if (exp_ar32.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL ar32_unexpected: got 0x%0h, expected none", b32.ar_addr);
                end else begin
                    check("ar_addr32", 64'(b32.ar_addr), 64'(exp_ar32.pop_front()));
                end
                have  = 1'b1;
                haddr = b32.ar_addr;
            end
        end
    end

    // Delivery monitor: compares every accepted head against the expected queues.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk); #2;
            if (rst_n && b64.inst_valid && b64.inst_ready && !rv64) begin
                if (exp_in64.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL inst64_unexpected: got pc 0x%0h, expected none", b64.inst_pc);
                end else begin
                    e = exp_in64.pop_front();
                    check("inst64", 64'(b64.inst), 64'(e.inst));
                    check("inst_pc64", b64.inst_pc, e.pc);
                    check("inst_err64", 64'(b64.inst_err), 64'(e.err));
                end
            end
            if (rst_n && b32.inst_valid && b32.inst_ready && !rv32) begin
                if (exp_in32.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL inst32_unexpected: got pc 0x%0h, expected none", b32.inst_pc);
                end else begin
                    e = exp_in32.pop_front();
                    check("inst32", 64'(b32.inst), 64'(e.inst));
                    check("inst_pc32", b32.inst_pc, e.pc);
                    check("inst_err32", 64'(b32.inst_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  base;
        logic seen;
        rst_n = 1'b0; rv64 = 1'b0; rv32 = 1'b0; rpc64 = '0; rpc32 = '0;
        b64.inst_ready = 1'b0; b32.inst_ready = 1'b0;
        cycles(3); #2;
        check("rst_ar_valid", 64'(b64.ar_valid), 64'd0);
        check("rst_r_ready", 64'(b64.r_ready), 64'd0);
        check("rst_inst_valid", 64'(b64.inst_valid), 64'd0);
        check("rst_fq_count", 64'(fq64), 64'd0);
        check("rst_inst", 64'(b64.inst), 64'd0);
        check("rst_inst_pc", b64.inst_pc, 64'd0);
        check("rst_inst_err", 64'(b64.inst_err), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic zero-wait fetch of two words sharing one aligned doubleword.
        exp_ar64.push_back(32'h8000_0000);
        exp_ar64.push_back(32'h8000_0000);
        exp_in64.push_back(mk(32'h0000_0413, 64'h8000_0000, 1'b0));
        exp_in64.push_back(mk(32'h0010_0093, 64'h8000_0004, 1'b0));
        b64.inst_ready = 1'b1;
        budget64 = 2;
        cycles(12);

        // Bus error on 0x80000008 is delivered and fetch continues at 0x8000000C.
        err_addr = 32'h8000_0008; err_arm = 1'b1;
        exp_ar64.push_back(32'h8000_0008);
        exp_ar64.push_back(32'h8000_0008);
        exp_in64.push_back(mk(word_at(32'h8000_0008), 64'h8000_0008, 1'b1));
        exp_in64.push_back(mk(word_at(32'h8000_000C), 64'h8000_000C, 1'b0));
        budget64 = 2;
        cycles(12);

        // Credit: with decode stalled exactly FQ_DEPTH requests issue.
        b64.inst_ready = 1'b0;
        base = ar_count64;
        exp_ar64.push_back(32'h8000_0010);
        exp_ar64.push_back(32'h8000_0010);
        exp_ar64.push_back(32'h8000_0018);
        exp_ar64.push_back(32'h8000_0018);
        exp_ar64.push_back(32'h8000_0020);
        budget64 = 5;
        cycles(20); #2;
        check("credit_fq_count", 64'(fq64), 64'd4);
        check("credit_ar_valid", 64'(b64.ar_valid), 64'd0);
        check("credit_ar_count", 64'(ar_count64 - base), 64'd4);
        check("credit_head_pc", b64.inst_pc, 64'h8000_0010);
        exp_in64.push_back(mk(word_at(32'h8000_0010), 64'h8000_0010, 1'b0));
        @(negedge clk); b64.inst_ready = 1'b1;
        @(negedge clk); b64.inst_ready = 1'b0;
        cycles(10); #2;
        check("credit_refill_count", 64'(ar_count64 - base), 64'd5);
        check("credit_refill_fq", 64'(fq64), 64'd4);
        check("credit_refill_ar_valid", 64'(b64.ar_valid), 64'd0);
        exp_in64.push_back(mk(word_at(32'h8000_0014), 64'h8000_0014, 1'b0));
        exp_in64.push_back(mk(word_at(32'h8000_0018), 64'h8000_0018, 1'b0));
        exp_in64.push_back(mk(word_at(32'h8000_001C), 64'h8000_001C, 1'b0));
        exp_in64.push_back(mk(word_at(32'h8000_0020), 64'h8000_0020, 1'b0));
        @(negedge clk); b64.inst_ready = 1'b1;
        cycles(12);

        // Redirect while DATA waits on a late beat: flush, drain, restart at target.
        b64.inst_ready = 1'b0;
        exp_ar64.push_back(32'h8000_0020);
        budget64 = 1;
        cycles(6); #2;
        check("pre_redirect_fq", 64'(fq64), 64'd1);
        exp_ar64.push_back(32'h8000_0028);
        r_delay64 = 3;
        budget64 = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #2;
            if (b64.r_ready && !b64.r_valid) seen = 1'b1;
        end
        check("data_wait_reached", 64'(seen), 64'd1);
        @(negedge clk); rv64 = 1'b1; rpc64 = 64'h8000_1000;
        @(negedge clk); rv64 = 1'b0; r_delay64 = 0; #2;
        check("flush_inst_valid", 64'(b64.inst_valid), 64'd0);
        check("flush_fq_count", 64'(fq64), 64'd0);
        exp_ar64.push_back(32'h8000_1000);
        exp_in64.push_back(mk(word_at(32'h8000_1000), 64'h8000_1000, 1'b0));
        b64.inst_ready = 1'b1;
        budget64 = 1;
        cycles(15);

        // Redirect coincident with the address handshake.
        @(negedge clk);
        exp_ar64.push_back(32'h8000_1000);
        exp_ar64.push_back(32'h8000_2000);
        exp_in64.push_back(mk(word_at(32'h8000_2000), 64'h8000_2000, 1'b0));
        budget64 = 2;
        rv64 = 1'b1; rpc64 = 64'h8000_2000;
        @(negedge clk); rv64 = 1'b0;
        cycles(12);

        // Redirect coincident with r_valid: the beat must be discarded.
        @(negedge clk);
        exp_ar64.push_back(32'h8000_2000);
        budget64 = 1;
        @(negedge clk); rv64 = 1'b1; rpc64 = 64'h8000_3000;
        @(negedge clk); rv64 = 1'b0; #2;
        check("rvalid_redirect_fq", 64'(fq64), 64'd0);
        check("rvalid_redirect_inst_valid", 64'(b64.inst_valid), 64'd0);
        @(negedge clk);
        exp_ar64.push_back(32'h8000_3000);
        exp_in64.push_back(mk(word_at(32'h8000_3000), 64'h8000_3000, 1'b0));
        budget64 = 1;
        cycles(12);

        // 32-bit bus build: misaligned redirect target is word-aligned.
        @(negedge clk); rv32 = 1'b1; rpc32 = 64'h8000_0006;
        @(negedge clk); rv32 = 1'b0;
        exp_ar32.push_back(32'h8000_0000);
        exp_ar32.push_back(32'h8000_0004);
        exp_in32.push_back(mk(32'h0010_0093, 64'h8000_0004, 1'b0));
        b32.inst_ready = 1'b1;
        budget32 = 2;
        cycles(12); #2;
        check("bus32_next_ar_addr", 64'(b32.ar_addr), 64'h8000_0008);
        check("bus32_next_ar_valid", 64'(b32.ar_valid), 64'd1);

        check("exp_ar64_left", 64'(exp_ar64.size()), 64'd0);
        check("exp_in64_left", 64'(exp_in64.size()), 64'd0);
        check("exp_ar32_left", 64'(exp_ar32.size()), 64'd0);
        check("exp_in32_left", 64'(exp_in32.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
